// File: rtl/taxi_sync_debounce_if.sv
// Bundle of level inputs, control and filtered status outputs for the
// per-lane debounce / edge-detect block.
interface taxi_sync_debounce_if #(
    parameter int WIDTH = 1,
    parameter int CNT_W = 16,
    parameter int EVT_W = 8
) ();

    logic [WIDTH-1:0] in;
    logic [CNT_W-1:0] stable_cycles;
    logic             evt_clr;
    logic [WIDTH-1:0] out;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic [EVT_W-1:0] evt_count;

    // Source of levels and control; consumer of filtered status
    modport master (
        output in,
        output stable_cycles,
        output evt_clr,
        input  out,
        input  rise,
        input  fall,
        input  evt_count
    );

    // The filter itself
    modport slave (
        input  in,
        input  stable_cycles,
        input  evt_clr,
        output out,
        output rise,
        output fall,
        output evt_count
    );

endinterface

// File: rtl/taxi_sync_debounce.sv
// Per-lane glitch filter with rise/fall pulse generation and a saturating
// count of filtered transitions. Inputs are assumed already synchronized.
module taxi_sync_debounce #(
    parameter int               WIDTH = 1,
    parameter int               CNT_W = 16,
    parameter int               EVT_W = 8,
    parameter logic [WIDTH-1:0] INIT  = {WIDTH{1'b0}}
) (
    input  logic                 clk,
    input  logic                 rst_n,
    taxi_sync_debounce_if.slave  bus
);

    localparam int SUM_W = EVT_W + $clog2(WIDTH + 1);
    localparam logic [SUM_W-1:0] EVT_MAX = SUM_W'({EVT_W{1'b1}});

    typedef enum logic [0:0] {StStable, StQualify} state_e;

    state_e           state_q [WIDTH];
    logic [CNT_W-1:0] cnt_q   [WIDTH];
    logic [CNT_W:0]   cnt_inc [WIDTH];
    logic [WIDTH-1:0] out_q;
    logic [WIDTH-1:0] rise_q;
    logic [WIDTH-1:0] fall_q;
    logic [EVT_W-1:0] evt_q;
    logic [EVT_W-1:0] evt_d;

    logic [CNT_W-1:0] n_eff;
    logic [WIDTH-1:0] disagree;
    logic [WIDTH-1:0] flip;
    logic [SUM_W-1:0] flip_cnt;
    logic [SUM_W-1:0] evt_sum;

    // A programmed length of zero behaves like one
    assign n_eff = (bus.stable_cycles == '0) ? CNT_W'(1) : bus.stable_cycles;

    // Per-lane flip decision for this edge
    always_comb begin
        disagree = bus.in ^ out_q;
        flip     = '0;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_inc[i] = {1'b0, cnt_q[i]} + 1'b1;
            unique case (state_q[i])
                StStable:  flip[i] = disagree[i] && (n_eff == CNT_W'(1));
                // >= so a lowered N mid-qualification flips on the next edge
                StQualify: flip[i] = disagree[i] && (cnt_inc[i] >= {1'b0, n_eff});
                default:   flip[i] = 1'b0;
            endcase
        end
    end

    // Lane FSMs, filtered levels and edge pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q  <= INIT;
            rise_q <= '0;
            fall_q <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                state_q[i] <= StStable;
                cnt_q[i]   <= '0;
            end
        end else begin
            out_q  <= out_q ^ flip;
            rise_q <= flip & ~out_q;
            fall_q <= flip & out_q;
            for (int i = 0; i < WIDTH; i++) begin
                unique case (state_q[i])
                    StStable: begin
                        if (disagree[i] && !flip[i]) begin
                            state_q[i] <= StQualify;
                            cnt_q[i]   <= CNT_W'(1);
                        end
                    end
                    StQualify: begin
                        if (!disagree[i] || flip[i]) begin
                            state_q[i] <= StStable;
                            cnt_q[i]   <= '0;
                        end else begin
                            cnt_q[i] <= cnt_inc[i][CNT_W-1:0];
                        end
                    end
                    default: begin
                        state_q[i] <= StStable;
                        cnt_q[i]   <= '0;
                    end
                endcase
            end
        end
    end

    // Saturating event total; flips coincident with a clear are kept
    always_comb begin
        flip_cnt = '0;
        for (int i = 0; i < WIDTH; i++) begin
            flip_cnt = flip_cnt + SUM_W'(flip[i]);
        end
        evt_sum = (bus.evt_clr ? '0 : SUM_W'(evt_q)) + flip_cnt;
        evt_d   = (evt_sum > EVT_MAX) ? {EVT_W{1'b1}} : evt_sum[EVT_W-1:0];
    end

    // Event counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            evt_q <= '0;
        end else begin
            evt_q <= evt_d;
        end
    end

    assign bus.out       = out_q;
    assign bus.rise      = rise_q;
    assign bus.fall      = fall_q;
    assign bus.evt_count = evt_q;

endmodule

// File: tb/tb_taxi_sync_debounce.sv
// Scoreboard bench for taxi_sync_debounce: the driver runs a run-length
// reference model and queues expected outputs; the monitor compares them.
module tb_taxi_sync_debounce;

    localparam int         W     = 4;
    localparam int         CW    = 16;
    localparam int         EW    = 3;
    localparam logic [3:0] INITV = 4'b0101;
    localparam int         EMAX  = 7;

    typedef struct packed {
        logic [3:0] out;
        logic [3:0] rise;
        logic [3:0] fall;
        logic [2:0] evt;
    } exp_t;

    logic clk;
    logic rst_n;

    taxi_sync_debounce_if #(.WIDTH(W), .CNT_W(CW), .EVT_W(EW)) bus ();

    taxi_sync_debounce #(
        .WIDTH (W),
        .CNT_W (CW),
        .EVT_W (EW),
        .INIT  (INITV)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model state: filtered level and consecutive-disagreement run length
    logic [3:0] m_out;
    logic [3:0] m_rise;
    logic [3:0] m_fall;
    int         m_evt;
    int         run[W];
    logic [3:0] cur_in;

    task automatic step(input logic [3:0] i_in, input int n, input logic clr,
                        input logic rst);
        int nn;
        int f;
        @(negedge clk);
        bus.in            = i_in;
        bus.stable_cycles = CW'(n);
        bus.evt_clr       = clr;
        rst_n             = rst;
        cur_in            = i_in;
        if (!rst) begin
            m_out  = INITV;
            m_rise = '0;
            m_fall = '0;
            m_evt  = 0;
            for (int i = 0; i < W; i++) run[i] = 0;
        end else begin
            nn     = (n == 0) ? 1 : n;
            f      = 0;
            m_rise = '0;
            m_fall = '0;
            for (int i = 0; i < W; i++) begin
                if (i_in[i] != m_out[i]) begin
                    run[i] = run[i] + 1;
                    if (run[i] >= nn) begin
                        if (m_out[i]) m_fall[i] = 1'b1;
                        else          m_rise[i] = 1'b1;
                        m_out[i] = ~m_out[i];
                        run[i]   = 0;
                        f++;
                    end
                end else begin
                    run[i] = 0;
                end
            end
            m_evt = clr ? f : m_evt + f;
            if (m_evt > EMAX) m_evt = EMAX;
        end
        exp_q.push_back('{out: m_out, rise: m_rise, fall: m_fall, evt: 3'(m_evt)});
    endtask

    task automatic hold(input logic [3:0] i_in, input int n, input int cycles);
        for (int k = 0; k < cycles; k++) step(i_in, n, 1'b0, 1'b1);
    endtask

    // Monitor: the DUT presents a status word every cycle
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                checks++;
                if (bus.out !== e.out || bus.rise !== e.rise || bus.fall !== e.fall ||
                    bus.evt_count !== e.evt) begin
                    errors++;
                    $display("FAIL status t=%0t got out=%b rise=%b fall=%b evt=%0d want out=%b rise=%b fall=%b evt=%0d",
                             $time, bus.out, bus.rise, bus.fall, bus.evt_count,
                             e.out, e.rise, e.fall, e.evt);
                end
            end
        end
    end

    initial begin
        logic [3:0] v;
        int         n;
        rst_n             = 1'b0;
        bus.in            = INITV;
        bus.stable_cycles = '0;
        bus.evt_clr       = 1'b0;
        cur_in            = INITV;

        // Reset values, then a quiet period
        for (int k = 0; k < 5; k++) step(INITV, 4, 1'b0, 1'b0);
        hold(INITV, 4, 100);

        // N=4 qualification on lane 1 (reset low)
        step(INITV, 4, 1'b1, 1'b1);
        hold(4'b0111, 4, 8);
        hold(4'b0101, 4, 8);

        // Glitch of 3 cycles is rejected; 4 cycles passes and returns
        step(INITV, 4, 1'b1, 1'b1);
        hold(4'b0111, 4, 3);
        hold(4'b0101, 4, 6);
        hold(4'b0111, 4, 4);
        hold(4'b0101, 4, 8);

        // N=0 and N=1 with lane 1 toggling every cycle
        for (int m = 0; m < 2; m++) begin
            step(INITV, m, 1'b1, 1'b1);
            v = INITV;
            for (int k = 0; k < 10; k++) begin
                v[1] = ~v[1];
                step(v, m, 1'b0, 1'b1);
            end
            hold(INITV, m, 3);
        end

        // Saturation with all lanes flipping, then a clear coincident with 4 flips
        step(cur_in, 1, 1'b1, 1'b1);
        v = cur_in;
        for (int k = 0; k < 4; k++) begin
            v = ~v;
            step(v, 1, 1'b0, 1'b1);
        end
        v = ~v;
        step(v, 1, 1'b1, 1'b1);
        hold(v, 1, 2);

        // Reset mid-qualification at N=8, then a fresh full qualification
        step(INITV, 8, 1'b0, 1'b0);
        hold(INITV, 8, 3);
        hold(4'b0001, 8, 5);
        step(4'b0001, 8, 1'b0, 1'b0);
        step(4'b0001, 8, 1'b0, 1'b0);
        hold(4'b0001, 8, 10);

        // Lowering N mid-qualification flips on the next disagreeing edge
        hold(4'b0101, 8, 5);
        hold(4'b0101, 3, 2);

        // Random traffic
        v = cur_in;
        n = 2;
        for (int k = 0; k < 3000; k++) begin
            for (int i = 0; i < W; i++) if ($urandom_range(0, 5) == 0) v[i] = ~v[i];
            if ($urandom_range(0, 40) == 0) n = int'($urandom_range(0, 6));
            step(v, n, ($urandom_range(0, 15) == 0), ($urandom_range(0, 300) != 0));
        end
        hold(v, n, 10);

        @(posedge clk);
        #2;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain pending=%0d want 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
